// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap controller:
// CSR addresses, mstatus bit positions, cause codes, the decoder
// cause encoding and the controller FSM states.
package trap_pkg;

    // Trap CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    // Writable mstatus fields
    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;

    // mcause codes; external IRQ i reports code IRQ_CODE_BASE + i
    localparam int unsigned CAUSE_ILLEGAL_INSTR = 2;
    localparam int unsigned CAUSE_ECALL_M       = 11;
    localparam int unsigned IRQ_CODE_BASE       = 16;

    // Decoder cause encoding on int_cause
    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_ECALL   = 2'b10,
        CAUSE_RSVD    = 2'b11
    } int_cause_e;

    // Controller states
    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } trap_state_e;

    // Index width for an n-entry encoder; at least one bit
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/trap_unit_irq_prio_enc.sv
// Lowest-index-wins priority encoder over the enabled pending interrupts.
// Ports:
//   req     - request vector (mip & mie, one bit per channel)
//   valid_c - any request set
//   idx_c   - index of the lowest set request (0 when none)
module irq_prio_enc
    import trap_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    output logic          valid_c,
    output logic [IW-1:0] idx_c
);

    // Scan from the top so the lowest set index is the last one written
    always_comb begin
        valid_c = 1'b0;
        idx_c   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid_c = 1'b1;
                idx_c   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/trap_unit.sv
// Machine-mode trap controller: edge-latched external interrupts,
// decoder exceptions, mret, and the trap CSRs (mstatus, mie, mip,
// mtvec, mepc, mcause). Issues a registered one-cycle PC redirect.
// Optional feature macro: TRAP_VECTORED_EN (honour mtvec vectored mode
// for interrupts; when undefined mtvec[1:0] is read-only 0).
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   instr_valid         - an instruction retires this cycle
//   int_cause           - decoder cause (none/illegal/ecall/reserved)
//   mret                - retiring instruction is mret
//   pc, pc_next         - PC of retiring instruction and its fall-through
//   irq                 - external interrupt lines, active high
//   csr_we/addr/wdata   - CSR write port (qualified by instr_valid)
//   csr_rdata           - combinational CSR read of csr_addr
//   redirect            - one-cycle flush + load redirect_pc
//   redirect_pc         - redirect target
module trap_unit
    import trap_pkg::*;
#(
    parameter int unsigned     NUM_IRQ   = 4,
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    input  logic [1:0]         int_cause,
    input  logic               mret,
    input  logic [XLEN-1:0]    pc,
    input  logic [XLEN-1:0]    pc_next,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               csr_we,
    input  logic [11:0]        csr_addr,
    input  logic [XLEN-1:0]    csr_wdata,
    output logic [XLEN-1:0]    csr_rdata,
    output logic               redirect,
    output logic [XLEN-1:0]    redirect_pc
);

    localparam int unsigned IW     = idx_width(NUM_IRQ);
    localparam int unsigned IRQ_LO = IRQ_CODE_BASE;

    trap_state_e        state_q, state_d;
    logic [NUM_IRQ-1:0] mie_q, mip_q, mip_d, irq_q;
    logic               mstatus_mie_q, mstatus_mpie_q;
    logic [XLEN-3:0]    mtvec_base_q, mepc_q, pcn_q;
    logic [XLEN-1:0]    mcause_q;
`ifdef TRAP_VECTORED_EN
    logic [1:0]         mtvec_mode_q;
`endif

    int_cause_e         cause_c;
    logic [NUM_IRQ-1:0] pending_c, irq_edge_c;
    logic               irq_any_c;
    logic [IW-1:0]      irq_idx_c;
    logic               take_exc_c, take_mret_c, take_irq_c, take_any_c, csr_wr_c;
    logic [XLEN-1:0]    mtvec_base_c, mtvec_rd_c, irq_code_c, irq_cause_c, exc_cause_c;
    logic [XLEN-1:0]    target_c;
    logic               unused_c;

    assign cause_c      = int_cause_e'(int_cause);
    assign pending_c    = mip_q & mie_q;
    assign irq_edge_c   = irq & ~irq_q;
    assign mtvec_base_c = {mtvec_base_q, 2'b00};
`ifdef TRAP_VECTORED_EN
    assign mtvec_rd_c   = {mtvec_base_q, mtvec_mode_q};
`else
    assign mtvec_rd_c   = mtvec_base_c;
`endif
    assign irq_code_c   = XLEN'(IRQ_CODE_BASE) + XLEN'(irq_idx_c);
    assign irq_cause_c  = {1'b1, irq_code_c[XLEN-2:0]};
    assign exc_cause_c  = (cause_c == CAUSE_ECALL) ? XLEN'(CAUSE_ECALL_M)
                                                   : XLEN'(CAUSE_ILLEGAL_INSTR);
    assign take_any_c   = take_exc_c | take_mret_c | take_irq_c;
    // Low PC bits never reach architectural state
    assign unused_c     = ^{pc[1:0], pc_next[1:0]};

    irq_prio_enc #(.N(NUM_IRQ)) u_prio (
        .req     (pending_c),
        .valid_c (irq_any_c),
        .idx_c   (irq_idx_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // Next state: any taken event spends exactly one cycle in REDIRECT
    always_comb begin
        state_d = ST_RUN;
        if (state_q == ST_RUN && take_any_c) state_d = ST_REDIRECT;
    end

    // Event arbitration and redirect target
    always_comb begin
        take_exc_c  = 1'b0;
        take_mret_c = 1'b0;
        take_irq_c  = 1'b0;
        csr_wr_c    = 1'b0;
        target_c    = mtvec_base_c;
        if (state_q == ST_RUN) begin
            if (instr_valid && cause_c != CAUSE_NONE) take_exc_c  = 1'b1;
            else if (instr_valid && mret)             take_mret_c = 1'b1;
            else if (mstatus_mie_q && irq_any_c)      take_irq_c  = 1'b1;
            else if (instr_valid && csr_we)           csr_wr_c    = 1'b1;
        end
        if (take_mret_c) target_c = {mepc_q, 2'b00};
`ifdef TRAP_VECTORED_EN
        else if (take_irq_c && mtvec_mode_q == 2'd1)
            target_c = mtvec_base_c + (irq_code_c << 2);
`endif
    end

    // Registered redirect outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            redirect <= take_any_c;
            if (take_any_c) redirect_pc <= target_c;
        end
    end

    // Pending bits: taken/software clears first, a fresh edge wins
    always_comb begin
        mip_d = mip_q;
        if (take_irq_c) mip_d[irq_idx_c] = 1'b0;
        if (csr_wr_c && csr_addr == CSR_MIP) mip_d = mip_d & csr_wdata[IRQ_LO +: NUM_IRQ];
        mip_d = mip_d | irq_edge_c;
    end

    // Trap CSRs, edge detectors and last fall-through PC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mip_q          <= '0;
            irq_q          <= '0;
            mtvec_base_q   <= MTVEC_RST[XLEN-1:2];
`ifdef TRAP_VECTORED_EN
            mtvec_mode_q   <= MTVEC_RST[1:0];
`endif
            mepc_q         <= '0;
            mcause_q       <= '0;
            pcn_q          <= '0;
        end else begin
            mip_q <= mip_d;
            irq_q <= irq;
            if (state_q == ST_RUN && instr_valid) pcn_q <= pc_next[XLEN-1:2];
            if (take_exc_c || take_irq_c) begin
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
                mcause_q       <= take_exc_c ? exc_cause_c : irq_cause_c;
                if (take_exc_c)       mepc_q <= pc[XLEN-1:2];
                else if (instr_valid) mepc_q <= pc_next[XLEN-1:2];
                else                  mepc_q <= pcn_q;
            end else if (take_mret_c) begin
                mstatus_mie_q  <= mstatus_mpie_q;
                mstatus_mpie_q <= 1'b1;
            end else if (csr_wr_c) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        mstatus_mie_q  <= csr_wdata[MSTATUS_MIE_BIT];
                        mstatus_mpie_q <= csr_wdata[MSTATUS_MPIE_BIT];
                    end
                    CSR_MIE:    mie_q <= csr_wdata[IRQ_LO +: NUM_IRQ];
                    CSR_MTVEC: begin
                        mtvec_base_q <= csr_wdata[XLEN-1:2];
`ifdef TRAP_VECTORED_EN
                        mtvec_mode_q <= csr_wdata[1:0];
`endif
                    end
                    CSR_MEPC:   mepc_q   <= csr_wdata[XLEN-1:2];
                    CSR_MCAUSE: mcause_q <= csr_wdata;
                    default: ;
                endcase
            end
        end
    end

    // Combinational CSR read; unmapped addresses read 0
    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_rdata[MSTATUS_MIE_BIT]  = mstatus_mie_q;
                csr_rdata[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
            end
            CSR_MIE:    csr_rdata[IRQ_LO +: NUM_IRQ] = mie_q;
            CSR_MIP:    csr_rdata[IRQ_LO +: NUM_IRQ] = mip_q;
            CSR_MTVEC:  csr_rdata = mtvec_rd_c;
            CSR_MEPC:   csr_rdata = {mepc_q, 2'b00};
            CSR_MCAUSE: csr_rdata = mcause_q;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_unit.sv
// Self-checking bench for trap_unit: directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the
// trap rules kept in this file.
module tb_trap_unit;

    localparam int unsigned NUM_IRQ   = 4;
    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] MTVEC_RST = 32'h100;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MIP     = 12'h344;
    localparam logic [11:0] A_UNMAP   = 12'h340;

    logic        clk, rst_n, instr_valid, mret, csr_we, redirect;
    logic [1:0]  int_cause;
    logic [31:0] pc, pc_next, csr_wdata, csr_rdata, redirect_pc;
    logic [3:0]  irq;
    logic [11:0] csr_addr;

    trap_unit #(.NUM_IRQ(NUM_IRQ), .XLEN(XLEN), .MTVEC_RST(MTVEC_RST)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .int_cause   (int_cause),
        .mret        (mret),
        .pc          (pc),
        .pc_next     (pc_next),
        .irq         (irq),
        .csr_we      (csr_we),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Architectural model of the trap CSRs as software sees them
    logic [31:0] m_mstatus, m_mie, m_mip, m_mtvec, m_mepc, m_mcause, m_last_pcn, m_rpc;
    logic [3:0]  m_prev_irq;
    bit          m_redir;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mstatus = 0; m_mie = 0; m_mip = 0; m_mtvec = MTVEC_RST;
`ifndef TRAP_VECTORED_EN
        m_mtvec = MTVEC_RST & ~32'h3;
`endif
        m_mepc = 0; m_mcause = 0; m_last_pcn = 0; m_rpc = 0;
        m_prev_irq = 0; m_redir = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            A_MSTATUS: return m_mstatus;
            A_MIE:     return m_mie;
            A_MIP:     return m_mip;
            A_MTVEC:   return m_mtvec;
            A_MEPC:    return m_mepc;
            A_MCAUSE:  return m_mcause;
            default:   return 32'h0;
        endcase
    endfunction

    // Apply one clock edge's worth of the trap rules to the model
    task automatic model_edge();
        logic [31:0] edges, pend, target;
        bit taken;
        int code;
        edges  = 32'(irq & ~m_prev_irq) << 16;
        pend   = m_mip & m_mie;
        taken  = 0;
        target = m_mtvec & ~32'h3;
        if (!m_redir) begin
            if (instr_valid && int_cause != 2'b00) begin
                m_mepc    = pc & ~32'h3;
                m_mcause  = (int_cause == 2'b10) ? 32'd11 : 32'd2;
                m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
                taken     = 1;
            end else if (instr_valid && mret) begin
                target    = m_mepc;
                m_mstatus = m_mstatus[7] ? 32'h88 : 32'h80;
                taken     = 1;
            end else if (m_mstatus[3] && pend != 0) begin
                code = 16;
                while (!pend[code]) code++;
                m_mip[code] = 1'b0;
                m_mepc      = (instr_valid ? pc_next : m_last_pcn) & ~32'h3;
                m_mcause    = 32'h8000_0000 | 32'(code);
                m_mstatus   = 32'h80;
`ifdef TRAP_VECTORED_EN
                if ((m_mtvec & 32'h3) == 32'h1) target = target + 32'(4 * code);
`endif
                taken = 1;
            end else if (instr_valid && csr_we) begin
                case (csr_addr)
                    A_MSTATUS: m_mstatus = csr_wdata & 32'h88;
                    A_MIE:     m_mie     = csr_wdata & 32'h000F_0000;
                    A_MIP:     m_mip     = m_mip & csr_wdata;
`ifdef TRAP_VECTORED_EN
                    A_MTVEC:   m_mtvec   = csr_wdata;
`else
                    A_MTVEC:   m_mtvec   = csr_wdata & ~32'h3;
`endif
                    A_MEPC:    m_mepc    = csr_wdata & ~32'h3;
                    A_MCAUSE:  m_mcause  = csr_wdata;
                    default: ;
                endcase
            end
            if (instr_valid) m_last_pcn = pc_next;
        end
        m_mip      = m_mip | edges;
        m_prev_irq = irq;
        if (taken) m_rpc = target;
        m_redir = taken;
    endtask

    task automatic drive(input bit iv, input logic [1:0] cause, input bit mr,
                         input logic [31:0] pcv, input logic [31:0] pcn, input logic [3:0] iq,
                         input bit we, input logic [11:0] a, input logic [31:0] wd);
        instr_valid = iv; int_cause = cause; mret = mr; pc = pcv; pc_next = pcn;
        irq = iq; csr_we = we; csr_addr = a; csr_wdata = wd;
    endtask

    task automatic idle(input logic [3:0] iq);
        drive(0, 2'b00, 0, 32'h0, 32'h0, iq, 0, A_UNMAP, 32'h0);
    endtask

    // One clock: advance model, then compare outputs after the edge
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("redirect", 32'(redirect), 32'(m_redir));
        chk("redirect_pc", redirect_pc, m_rpc);
        chk($sformatf("csr_rdata@%h", csr_addr), csr_rdata, model_read(csr_addr));
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        csr_we = 0; csr_addr = a; #1; d = csr_rdata;
    endtask

    task automatic check_all(input string tag);
        logic [11:0] addrs [7];
        addrs = '{A_MSTATUS, A_MIE, A_MTVEC, A_MEPC, A_MCAUSE, A_MIP, A_UNMAP};
        for (int i = 0; i < 7; i++) begin
            csr_we = 0; csr_addr = addrs[i]; #1;
            chk($sformatf("%s_%h", tag, addrs[i]), csr_rdata, model_read(addrs[i]));
        end
    endtask

    initial begin
        logic [31:0] d, exp_vec;
        logic [3:0]  iq;
        logic [11:0] pick [7];
        pick = '{A_MSTATUS, A_MIE, A_MTVEC, A_MEPC, A_MCAUSE, A_MIP, A_UNMAP};

        // Reset state
        rst_n = 1'b0;
        idle(4'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_redirect", 32'(redirect), 32'h0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        check_all("rst");
        rd(A_MTVEC, d); chk("rst_mtvec", d, 32'h100);
        @(negedge clk) rst_n = 1'b1;

        // Illegal instruction, direct target
        drive(1, 2'b00, 0, 32'h10, 32'h14, 4'h0, 1, A_MTVEC, 32'h200); tick();
        drive(1, 2'b01, 0, 32'h40, 32'h44, 4'h0, 0, A_UNMAP, 32'h0);  tick();
        chk("ill_redirect", 32'(redirect), 32'h1);
        chk("ill_target", redirect_pc, 32'h200);
        idle(4'h0); tick();
        rd(A_MEPC, d);    chk("ill_mepc", d, 32'h40);
        rd(A_MCAUSE, d);  chk("ill_mcause", d, 32'h2);
        rd(A_MSTATUS, d); chk("ill_mie", d & 32'h8, 32'h0);

        // IRQ1 via edge, taken one cycle after mip sets
        drive(1, 2'b00, 0, 32'h50, 32'h54, 4'h0, 1, A_MSTATUS, 32'h8);     tick();
        drive(1, 2'b00, 0, 32'h54, 32'h58, 4'h0, 1, A_MIE, 32'h0002_0000); tick();
        drive(1, 2'b00, 0, 32'h58, 32'h5c, 4'h0, 1, A_MTVEC, 32'h201);     tick();
        idle(4'b0010); tick();
        chk("irq_latency", 32'(redirect), 32'h0);
        drive(1, 2'b00, 0, 32'h80, 32'h84, 4'b0010, 0, A_UNMAP, 32'h0); tick();
`ifdef TRAP_VECTORED_EN
        exp_vec = 32'h244;
`else
        exp_vec = 32'h200;
`endif
        chk("irq1_target", redirect_pc, exp_vec);
        idle(4'b0010); tick();
        rd(A_MCAUSE, d); chk("irq1_mcause", d, 32'h8000_0011);
        rd(A_MEPC, d);   chk("irq1_mepc", d, 32'h84);
        rd(A_MIP, d);    chk("irq1_mip_clr", d & 32'h0002_0000, 32'h0);

        // IRQ0 and IRQ2 together: lowest first, IRQ2 after mret
        idle(4'h0); tick();
        drive(1, 2'b00, 0, 32'h60, 32'h64, 4'h0, 1, A_MIE, 32'h0005_0000); tick();
        idle(4'b0101); tick();
        drive(1, 2'b00, 1, 32'h90, 32'h94, 4'b0101, 0, A_UNMAP, 32'h0); tick();
        chk("mret1_target", redirect_pc, 32'h84);
        rd(A_MSTATUS, d); chk("mret1_mie", d & 32'h8, 32'h8);
        idle(4'b0101); tick();
        idle(4'b0101); tick();
        chk("irq0_first", 32'(redirect), 32'h1);
        rd(A_MCAUSE, d); chk("irq0_mcause", d, 32'h8000_0010);
        idle(4'b0101); tick();
        drive(1, 2'b00, 1, 32'ha0, 32'ha4, 4'b0101, 0, A_UNMAP, 32'h0); tick();
        chk("mret2_target", redirect_pc, 32'h94);
        rd(A_MSTATUS, d); chk("mret2_mie", d & 32'h8, 32'h8);
        idle(4'b0101); tick();
        idle(4'b0101); tick();
        rd(A_MCAUSE, d); chk("irq2_mcause", d, 32'h8000_0012);
        idle(4'h0); tick();

        // ecall with a colliding mtvec write
        drive(1, 2'b10, 0, 32'h300, 32'h304, 4'h0, 1, A_MTVEC, 32'hABC0); tick();
        chk("ecall_target", redirect_pc, 32'h200);
        idle(4'h0); tick();
        rd(A_MCAUSE, d); chk("ecall_mcause", d, 32'd11);
        rd(A_MTVEC, d);
`ifdef TRAP_VECTORED_EN
        chk("ecall_mtvec_kept", d, 32'h201);
`else
        chk("ecall_mtvec_kept", d, 32'h200);
`endif

        // Reset asserted during the redirect cycle
        drive(1, 2'b11, 0, 32'h500, 32'h504, 4'h0, 0, A_UNMAP, 32'h0); tick();
        chk("pre_rst_redirect", 32'(redirect), 32'h1);
        #1 rst_n = 1'b0;
        #1 chk("rst_drop_redirect", 32'(redirect), 32'h0);
        model_reset();
        check_all("rst2");
        @(negedge clk) rst_n = 1'b1;
        drive(1, 2'b01, 0, 32'h600, 32'h604, 4'h0, 0, A_UNMAP, 32'h0); tick();
        chk("post_rst_run", 32'(redirect), 32'h1);
        chk("post_rst_target", redirect_pc, 32'h100);

        // Randomized traffic
        iq = 4'h0;
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) iq[b] = ~iq[b];
            drive($urandom_range(0, 9) < 7,
                  ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                  $urandom_range(0, 19) == 0,
                  $urandom, $urandom, iq,
                  $urandom_range(0, 2) == 0,
                  pick[$urandom_range(0, 6)],
                  $urandom);
            tick();
            if (n % 60 == 59) check_all("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/trap_unit.md
# trap_unit

Parametrised machine-mode trap controller for the RISC-V core. Successor to the 2-bit `IntCause`/`MRet` control pair: it handles `NUM_IRQ` edge-latched external interrupt channels plus decoder exceptions, and owns the trap CSRs (`mstatus`, `mie`, `mip`, `mtvec`, `mepc`, `mcause`). It issues registered PC redirects with flush to the datapath. It sits beside the datapath's PC logic and takes its exception inputs from the control unit.

## Interface
- `NUM_IRQ`, 4: external interrupt channels, 1..16.
- `XLEN`, 32: data/PC width.
- `MTVEC_RST`, 32'h0000_0000: reset value of `mtvec`.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `instr_valid` input 1: an instruction retires this cycle.
- `int_cause` input 2: decoder cause. 00 none, 01 illegal instruction, 10 ecall, 11 reserved (treated as illegal).
- `mret` input 1: the retiring instruction is `mret`.
- `pc` input XLEN: PC of the retiring instruction.
- `pc_next` input XLEN: PC the retiring instruction would continue to.
- `irq` input NUM_IRQ: external interrupt lines, active high.
- `csr_we` input 1: CSR write strobe, qualified by `instr_valid`.
- `csr_addr` input 12: CSR address.
- `csr_wdata` input XLEN: CSR write data.
- `csr_rdata` output XLEN: combinational read of `csr_addr`. Unmapped addresses read 0.
- `redirect` output 1: flush the pipeline and load `redirect_pc`. Reset 0.
- `redirect_pc` output XLEN: redirect target. Reset 0.

## Operation
- FSM states:
  - RUN: default; accepts events.
  - REDIRECT: one cycle with `redirect` = 1; `instr_valid`, `mret`, `int_cause` and CSR writes are ignored. Always returns to RUN.
- Pending: `mip[i]` sets on a rising edge of `irq[i]`, using a one-flop edge detector per channel. It clears when IRQ i is taken or when software writes 0 to that bit of `mip`. A new edge in the same cycle as the clear wins (the bit stays set).
- Event priority in RUN when `instr_valid` = 1, highest first:
  1. exception (`int_cause` ≠ 00)
  2. `mret`
  3. interrupt (`mstatus.MIE` and any `mip & mie`; lowest index wins)
  4. CSR write
- Interrupts are also taken when `instr_valid` = 0, provided the enable conditions hold.
- Exception taken:
  - `mepc` ← `pc`
  - `mcause` ← 2 (illegal) or 11 (ecall)
  - MPIE ← MIE, MIE ← 0
  - target = `mtvec` base
- Interrupt taken:
  - `mepc` ← `pc_next` when `instr_valid`, else the last latched `pc_next`
  - `mcause` ← {1'b1, code 16+i}
  - MPIE ← MIE, MIE ← 0
  - target per Configuration
- `mret`: MIE ← MPIE, MPIE ← 1, target = `mepc`.
- A CSR write in the same cycle as any trap or `mret` is dropped.
- `mtvec[1:0]` is the mode field: 0 direct, 1 vectored. Base = `{mtvec[XLEN-1:2], 2'b00}`.
- `mepc[1:0]` is hardwired to 0.
- `mstatus`: only bit 3 (MIE) and bit 7 (MPIE) are writable; all other bits read 0.
- `mie`/`mip`: only bits 16..16+NUM_IRQ-1 are implemented.
- Arithmetic: vector offset = code×4, computed modulo 2^XLEN.

## Timing
- Decision is taken in cycle N. CSR updates land at edge N. `redirect` and `redirect_pc` are registered and valid in cycle N+1 for exactly one cycle.
- `irq` edge at edge K sets `mip` at edge K. The earliest the interrupt can be taken is cycle K+1.
- Back-to-back redirects cannot occur; the minimum spacing is 2 cycles.
- Reset values (asserted mid-redirect, `rst_n` low forces all of these immediately and returns the FSM to RUN):
  - `mtvec` = `MTVEC_RST`
  - all other CSRs 0
  - edge detectors 0
  - `redirect` = 0

## Configuration
- `TRAP_VECTORED_EN`:
  - Defined: vectored mode is honoured. An interrupt targets base + 4×code; exceptions always target base.
  - Undefined: `mtvec[1:0]` is read-only 0 and every trap targets base.

## Structure
- Package `trap_pkg` holds:
  - CSR address constants: 12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344
  - cause-code constants
  - the `int_cause` encoding enum
  - the FSM state enum
- Sub-module `irq_prio_enc`: parametrised lowest-index priority encoder over `mip & mie`, producing a valid flag and an index.

## Test plan
- Reset with `MTVEC_RST` = 32'h100: all reads 0 except `mtvec` = 32'h100; `redirect` = 0.
- Illegal instruction at `pc` = 32'h40, `mtvec` = 32'h200: next cycle `redirect` = 1, `redirect_pc` = 32'h200, `mepc` = 32'h40, `mcause` = 2, MIE = 0.
- MIE = 1, `mie[17]` set, edge on `irq[1]`, `pc_next` = 32'h84: `redirect_pc` = 32'h200, `mcause` = 32'h8000_0011, `mepc` = 32'h84, `mip[17]` cleared.
  - With `TRAP_VECTORED_EN` defined and `mtvec` = 32'h201: `redirect_pc` = 32'h244.
- `irq[0]` and `irq[2]` edges together with both enabled: IRQ0 is taken first. After `mret` (`redirect_pc` = `mepc`, MIE restored to 1), IRQ2 is taken.
- ecall with a simultaneous `csr_we` to `mtvec`: ecall trap taken, `mcause` = 11, `mtvec` unchanged.
- `rst_n` pulsed low during the REDIRECT cycle: `redirect` drops immediately, and the FSM is in RUN after release.
